// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES helpers: GF(2^8) arithmetic, S-boxes, rcon, inverse round functions, FSM states
package aes_pkg;

    typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC, S_DONE} aes_state_e;

    // Element 15 holds byte 0 (bits 127:120); byte i = row i%4, column i/4.
    typedef logic [15:0][7:0] aes_block_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t, m;
        p = 8'h00;
        t = a;
        m = b;
        for (int i = 0; i < 8; i++) begin
            if (m[0]) p = p ^ t;
            t = xtime(t);
            m = m >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon_byte(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        aes_block_t a, o;
        a = s;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[15 - (r + 4 * c)] = a[15 - (r + 4 * ((c - r + 4) % 4))];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        aes_block_t a, o;
        a = s;
        for (int i = 0; i < 16; i++)
            o[i] = inv_sbox(a[i]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        aes_block_t a, o;
        logic [7:0] b0, b1, b2, b3;
        a = s;
        for (int c = 0; c < 4; c++) begin
            b0 = a[15 - 4 * c];
            b1 = a[14 - 4 * c];
            b2 = a[13 - 4 * c];
            b3 = a[12 - 4 * c];
            o[15 - 4 * c] = gmul(b0, 8'h0e) ^ gmul(b1, 8'h0b) ^ gmul(b2, 8'h0d) ^ gmul(b3, 8'h09);
            o[14 - 4 * c] = gmul(b0, 8'h09) ^ gmul(b1, 8'h0e) ^ gmul(b2, 8'h0b) ^ gmul(b3, 8'h0d);
            o[13 - 4 * c] = gmul(b0, 8'h0d) ^ gmul(b1, 8'h09) ^ gmul(b2, 8'h0e) ^ gmul(b3, 8'h0b);
            o[12 - 4 * c] = gmul(b0, 8'h0b) ^ gmul(b1, 8'h0d) ^ gmul(b2, 8'h09) ^ gmul(b3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// rtl/aes_key_step.sv - combinational AES-128 round key step, forward (dir=0) or inverse (dir=1)
// Ports: dir selects direction; rcon is the round constant byte; key_in -> key_out one round key.
module aes_key_step
    import aes_pkg::*;
(
    input  logic         dir,
    input  logic [7:0]   rcon,
    input  logic [127:0] key_in,
    output logic [127:0] key_out
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] i0, i1, i2, i3;

    assign {w0, w1, w2, w3} = key_in;

    assign f0 = w0 ^ sub_rot_word(w3) ^ {rcon, 24'h000000};
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    // Recover the previous w3 first; the S-box term of w0 depends on it.
    assign i3 = w3 ^ w2;
    assign i2 = w2 ^ w1;
    assign i1 = w1 ^ w0;
    assign i0 = w0 ^ sub_rot_word(i3) ^ {rcon, 24'h000000};

    assign key_out = dir ? {i0, i1, i2, i3} : {f0, f1, f2, f3};

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 inverse cipher with on-the-fly round keys
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/ct_in/key_in accept a block;
//        out_valid/out_ready/pt_out return the plaintext.
module aes_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct_in,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt_out
);

    aes_state_e   state, state_d;
    logic [127:0] ct_r, rk, st;
    logic [3:0]   rnd;
    logic         key_dir;
    logic [7:0]   key_rcon;
    logic [127:0] k_next;
    logic [127:0] round_core;

    // Forward steps build key rnd+1; inverse steps undo key rnd, which was made with rcon[rnd].
    assign key_dir  = (state == S_DEC);
    assign key_rcon = rcon_byte(key_dir ? rnd : rnd + 4'd1);

    aes_key_step u_key_step (
        .dir     (key_dir),
        .rcon    (key_rcon),
        .key_in  (rk),
        .key_out (k_next)
    );

    assign round_core = inv_sub_bytes(inv_shift_rows(st)) ^ k_next;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign pt_out    = st;

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (in_valid)    state_d = S_KEXP;
            S_KEXP: if (rnd == 4'd9) state_d = S_DEC;
            S_DEC:  if (rnd == 4'd1) state_d = S_DONE;
            S_DONE: if (out_ready)   state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ct_r  <= '0;
            rk    <= '0;
            st    <= '0;
            rnd   <= '0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        ct_r <= ct_in;
                        rk   <= key_in;
                        rnd  <= 4'd0;
                    end
                end
                S_KEXP: begin
                    rk  <= k_next;
                    rnd <= rnd + 4'd1;
                    if (rnd == 4'd9)
                        st <= ct_r ^ k_next;
                end
                S_DEC: begin
                    rk  <= k_next;
                    rnd <= rnd - 4'd1;
                    // The final round omits InvMixColumns.
                    st  <= (rnd == 4'd1) ? round_core : inv_mix_columns(round_core);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - self-checking bench for aes_inv_cipher_iter
module tb_aes_inv_cipher_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct_in;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] pt_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb [256];

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs [3];

    always #5 clk = ~clk;

    aes_inv_cipher_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct_in     (ct_in),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt_out    (pt_out)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        logic [7:0] c, y;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            y[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8] ^ c[i];
        return y;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = affine(inv);
        end
    endtask

    // Forward AES-128 encryption with a fully expanded key schedule.
    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, x;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127 - 8 * i -: 8];
            s[i] = pt[127 - 8 * i -: 8];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                x = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[x];
                rc = mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4 * c] = t[row + 4 * ((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) tmp[j] = s[4 * c + j];
                    s[4 * c]     = mul(tmp[0], 8'h02) ^ mul(tmp[1], 8'h03) ^ tmp[2] ^ tmp[3];
                    s[4 * c + 1] = tmp[0] ^ mul(tmp[1], 8'h02) ^ mul(tmp[2], 8'h03) ^ tmp[3];
                    s[4 * c + 2] = tmp[0] ^ tmp[1] ^ mul(tmp[2], 8'h02) ^ mul(tmp[3], 8'h03);
                    s[4 * c + 3] = mul(tmp[0], 8'h03) ^ tmp[1] ^ tmp[2] ^ mul(tmp[3], 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16 * r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // Feeds one block, scrambles in_valid/ct_in/key_in/out_ready while busy, then stalls
    // out_ready low for 'stall' cycles before completing the output handshake.
    task automatic run_block(input logic [127:0] key, input logic [127:0] ct, input int stall,
                             output logic [127:0] pt, output int lat, output logic [127:0] rk10);
        int guard;
        guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("accept timeout in_ready", 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        ct_in    = ct;
        key_in   = key;
        @(negedge clk);
        lat  = 0;
        rk10 = '0;
        while (!out_valid && lat < 40) begin
            in_valid  = 1'($urandom);
            ct_in     = rand128();
            key_in    = rand128();
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
            if (lat == 10) rk10 = dut.rk;
        end
        pt = pt_out;
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            ct_in     = rand128();
            @(negedge clk);
            check("stall pt_out stable", pt_out, pt);
            check("stall in_ready low", 128'(in_ready), 128'd0);
            check("stall out_valid held", 128'(out_valid), 128'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle after handshake {out_valid,in_ready}", 128'({out_valid, in_ready}), 128'd1);
    endtask

    initial begin
        logic [127:0] got, rk10, pt, ct, key;
        int lat;

        vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                    ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    pt:  128'h00112233445566778899aabbccddeeff};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734};
        vecs[2] = '{key: 128'h0,
                    ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                    pt:  128'h0};

        build_sbox();

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ct_in     = '0;
        key_in    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset in_ready", 128'(in_ready), 128'd1);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset pt_out", pt_out, 128'd0);

        for (int v = 0; v < 3; v++) begin
            run_block(vecs[v].key, vecs[v].ct, 0, got, lat, rk10);
            check($sformatf("kat%0d pt_out", v), got, vecs[v].pt);
            check($sformatf("kat%0d latency", v), 128'(lat), 128'd20);
            if (v == 1) check("appB rk after E10", rk10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        end

        run_block(vecs[0].key, vecs[0].ct, 7, got, lat, rk10);
        check("backpressure pt_out", got, vecs[0].pt);
        check("backpressure latency", 128'(lat), 128'd20);

        // Abort a block part-way with reset.
        in_valid = 1'b1;
        ct_in    = vecs[1].ct;
        key_in   = vecs[1].key;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset out_valid", 128'(out_valid), 128'd0);
        check("midreset in_ready", 128'(in_ready), 128'd1);
        check("midreset pt_out", pt_out, 128'd0);
        @(negedge clk);
        check("midreset no late output", 128'(out_valid), 128'd0);
        run_block(vecs[0].key, vecs[0].ct, 0, got, lat, rk10);
        check("post-reset C.1 pt_out", got, vecs[0].pt);
        check("post-reset C.1 latency", 128'(lat), 128'd20);

        for (int n = 0; n < 1000; n++) begin
            key = rand128();
            pt  = rand128();
            ct  = model_encrypt(pt, key);
            run_block(key, ct, int'($urandom_range(0, 3)), got, lat, rk10);
            check("random round-trip", got, pt);
            check("random latency", 128'(lat), 128'd20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
